// File: rtl/bmem_line_arbiter.sv
// Arbitrates icache/dcache line requests onto the single 64-bit burst memory port.
// Latency: grant in IDLE, bmem request the next cycle; resp one cycle after the last beat.
// Backpressure: bmem_ready stalls issue and write beats; read beats wait on bmem_rvalid.
module bmem_line_arbiter #(
    parameter int BEATS      = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [31:0]           i_addr,
    input  logic                  i_read,
    input  logic                  i_write,
    input  logic [BEATS*64-1:0]   i_wdata,
    output logic [BEATS*64-1:0]   i_rdata,
    output logic                  i_resp,

    input  logic [31:0]           d_addr,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [BEATS*64-1:0]   d_wdata,
    output logic [BEATS*64-1:0]   d_rdata,
    output logic                  d_resp,

    output logic [31:0]           bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [63:0]           bmem_wdata,
    input  logic                  bmem_ready,
    input  logic [31:0]           bmem_raddr,
    input  logic [63:0]           bmem_rdata,
    input  logic                  bmem_rvalid
);

    localparam int LW   = BEATS * 64;
    localparam int KW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SW   = $clog2(STARVE_MAX + 1);
    localparam int OFFW = $clog2(BEATS * 8);
    localparam logic [KW-1:0] K_LAST     = KW'(BEATS - 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_BURST,
        RESP
    } state_t;

    state_t          state_q, state_d;
    logic            own_d_q, own_d_d;      // 1: dcache owns the port, 0: icache
    logic [31:0]     addr_q, addr_d;
    logic [LW-1:0]   line_q, line_d;        // write line to send, or read line being assembled
    logic [KW-1:0]   k_q, k_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic [LW-1:0]   i_rdata_q, i_rdata_d;
    logic [LW-1:0]   d_rdata_q, d_rdata_d;

    logic            i_req, d_req;
    logic            beat_hit;

    // Byte offset within a line is meaningless here; addresses are forced to line alignment.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{i_addr[OFFW-1:0], d_addr[OFFW-1:0]};

    assign i_req    = i_read | i_write;
    assign d_req    = d_read | d_write;
    assign beat_hit = bmem_rvalid && (bmem_raddr == addr_q);

    // Arbitration, burst sequencing and read-line assembly.
    always_comb begin
        state_d   = state_q;
        own_d_d   = own_d_q;
        addr_d    = addr_q;
        line_d    = line_q;
        k_d       = k_q;
        starve_d  = starve_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;

        case (state_q)
            IDLE: begin
                k_d = '0;
                if (i_req && (!d_req || starve_q == STARVE_LIM)) begin
                    own_d_d  = 1'b0;
                    addr_d   = {i_addr[31:OFFW], {OFFW{1'b0}}};
                    line_d   = i_wdata;
                    starve_d = '0;
                    state_d  = i_write ? WR_BURST : RD_ISSUE;
                end else if (d_req) begin
                    own_d_d  = 1'b1;
                    addr_d   = {d_addr[31:OFFW], {OFFW{1'b0}}};
                    line_d   = d_wdata;
                    starve_d = i_req ? starve_q + SW'(1) : '0;
                    state_d  = d_write ? WR_BURST : RD_ISSUE;
                end else begin
                    starve_d = '0;
                end
            end
            RD_ISSUE: begin
                if (bmem_ready) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (beat_hit) begin
                    line_d[k_q*64 +: 64] = bmem_rdata;
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        state_d = RESP;
                        if (own_d_q) begin
                            d_rdata_d = line_d;
                        end else begin
                            i_rdata_d = line_d;
                        end
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            WR_BURST: begin
                if (bmem_ready) begin
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        state_d = RESP;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any burst in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            own_d_q   <= 1'b0;
            addr_q    <= '0;
            line_q    <= '0;
            k_q       <= '0;
            starve_q  <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            own_d_q   <= own_d_d;
            addr_q    <= addr_d;
            line_q    <= line_d;
            k_q       <= k_d;
            starve_q  <= starve_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // Outputs decoded from state and latched registers only, never from cache inputs.
    always_comb begin
        bmem_read  = (state_q == RD_ISSUE);
        bmem_write = (state_q == WR_BURST);
        bmem_addr  = (bmem_read || bmem_write) ? addr_q : '0;
        bmem_wdata = bmem_write ? line_q[k_q*64 +: 64] : '0;
        i_resp     = (state_q == RESP) && !own_d_q;
        d_resp     = (state_q == RESP) &&  own_d_q;
        i_rdata    = i_rdata_q;
        d_rdata    = d_rdata_q;
    end

endmodule

// File: tb/tb_bmem_line_arbiter.sv
// Self-checking bench for bmem_line_arbiter with a memory-side responder and line-level model.
// Latency: checks issue cycle, beat order and resp timing relative to accepted beats.
// Backpressure: injects bmem_ready stalls, read gaps and foreign-address read beats.
module tb_bmem_line_arbiter;

    localparam int BEATS      = 4;
    localparam int STARVE_MAX = 4;
    localparam int LW         = BEATS * 64;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [31:0]     i_addr = '0;
    logic            i_read = 1'b0, i_write = 1'b0;
    logic [LW-1:0]   i_wdata = '0, i_rdata;
    logic            i_resp;
    logic [31:0]     d_addr = '0;
    logic            d_read = 1'b0, d_write = 1'b0;
    logic [LW-1:0]   d_wdata = '0, d_rdata;
    logic            d_resp;
    logic [31:0]     bmem_addr;
    logic            bmem_read, bmem_write;
    logic [63:0]     bmem_wdata;
    logic            bmem_ready = 1'b0;
    logic [31:0]     bmem_raddr = '0;
    logic [63:0]     bmem_rdata = '0;
    logic            bmem_rvalid = 1'b0;

    always #5 clk = ~clk;

    bmem_line_arbiter #(.BEATS(BEATS), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_write(i_write), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
        .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model of what each cache's rdata must hold (last completed read line).
    logic [LW-1:0] model_rdata [2];

    // Observations collected by xact for the calling test.
    bit            o_timeout, o_other_resp, o_resp_after, o_addr_bad, o_hold_bad;
    int            o_resp_t, o_last_beat_t, o_first_req_t, o_nstall;
    logic [31:0]   o_addr_first;
    logic [LW-1:0] o_rdata;
    logic [63:0]   o_beats [$];

    function automatic logic [31:0] align(input logic [31:0] a);
        return {a[31:5], 5'b0};
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int w = 0; w < LW / 32; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    // Runs one line transaction for one cache, acting as the memory on the bmem side.
    task automatic xact(input bit is_d, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [LW-1:0] wline, input logic [LW-1:0] rline,
                        input int stall_beat, input int stall_n, input bit rnd, input bit mism);
        logic [31:0] ea;
        logic [63:0] prev;
        int t, acc, nm, stalls;
        bit rd_acc, mm_done, done, have_prev, own, oth;
        ea = align(addr);
        o_timeout = 0; o_other_resp = 0; o_resp_after = 0; o_addr_bad = 0; o_hold_bad = 0;
        o_resp_t = -1; o_last_beat_t = -1; o_first_req_t = -1; o_nstall = 0;
        o_addr_first = '0; o_rdata = '0; o_beats.delete();
        t = 0; acc = 0; nm = 0; stalls = 0; prev = '0;
        rd_acc = 0; mm_done = 0; done = 0; have_prev = 0;
        @(negedge clk);
        if (is_d) begin d_addr = addr; d_read = rd; d_write = wr; d_wdata = wline; end
        else      begin i_addr = addr; i_read = rd; i_write = wr; i_wdata = wline; end
        while (!done && t < 400) begin
            @(negedge clk);
            t++;
            bmem_rvalid = 1'b0;
            bmem_ready  = 1'b0;
            own = is_d ? d_resp : i_resp;
            oth = is_d ? i_resp : d_resp;
            if (oth) o_other_resp = 1;
            if (own) begin
                o_resp_t = t;
                o_rdata  = is_d ? d_rdata : i_rdata;
                done     = 1;
                if (is_d) begin d_read = 1'b0; d_write = 1'b0; end
                else      begin i_read = 1'b0; i_write = 1'b0; end
            end else begin
                if (rd_acc && nm < BEATS) begin
                    if (mism && ((!mm_done && nm == 1) || $urandom_range(0, 4) == 0)) begin
                        mm_done     = 1;
                        bmem_rvalid = 1'b1;
                        bmem_raddr  = ea + 32'h20;
                        bmem_rdata  = {$urandom, $urandom};
                    end else if (rnd && $urandom_range(0, 3) == 0) begin
                        bmem_rvalid = 1'b0;
                    end else begin
                        bmem_rvalid = 1'b1;
                        bmem_raddr  = ea;
                        bmem_rdata  = rline[nm*64 +: 64];
                        nm++;
                        if (nm == BEATS) o_last_beat_t = t;
                    end
                end
                if (bmem_read) begin
                    if (o_first_req_t < 0) begin o_first_req_t = t; o_addr_first = bmem_addr; end
                    if (bmem_addr !== ea) o_addr_bad = 1;
                    bmem_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                    if (bmem_ready) rd_acc = 1;
                end
                if (bmem_write) begin
                    if (o_first_req_t < 0) begin o_first_req_t = t; o_addr_first = bmem_addr; end
                    if (bmem_addr !== ea) o_addr_bad = 1;
                    if (have_prev && bmem_wdata !== prev) o_hold_bad = 1;
                    if (acc == stall_beat && stalls < stall_n) begin
                        bmem_ready = 1'b0;
                        stalls++;
                    end else begin
                        bmem_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                    end
                    if (bmem_ready) begin
                        o_beats.push_back(bmem_wdata);
                        acc++;
                        have_prev = 0;
                    end else begin
                        o_nstall++;
                        have_prev = 1;
                        prev = bmem_wdata;
                    end
                end
            end
        end
        if (!done) begin
            o_timeout = 1;
            if (is_d) begin d_read = 1'b0; d_write = 1'b0; end
            else      begin i_read = 1'b0; i_write = 1'b0; end
        end
        @(negedge clk);
        bmem_ready  = 1'b0;
        bmem_rvalid = 1'b0;
        o_resp_after = is_d ? d_resp : i_resp;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_tests++; if (bmem_read !== 1'b0)   begin n_fail++; $display("FAIL reset_bmem_read got %0b want 0", bmem_read); end
        n_tests++; if (bmem_write !== 1'b0)  begin n_fail++; $display("FAIL reset_bmem_write got %0b want 0", bmem_write); end
        n_tests++; if (bmem_addr !== 32'h0)  begin n_fail++; $display("FAIL reset_bmem_addr got %0h want 0", bmem_addr); end
        n_tests++; if (bmem_wdata !== 64'h0) begin n_fail++; $display("FAIL reset_bmem_wdata got %0h want 0", bmem_wdata); end
        n_tests++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin n_fail++; $display("FAIL reset_resp got i=%0b d=%0b want 0", i_resp, d_resp); end
        n_tests++; if (i_rdata !== '0 || d_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata got i=%0h d=%0h want 0", i_rdata, d_rdata); end
        rst = 1'b0;
        model_rdata[0] = '0;
        model_rdata[1] = '0;
        @(negedge clk);
    endtask

    task automatic test_icache_read();
        logic [LW-1:0] rl;
        for (int k = 0; k < BEATS; k++) rl[k*64 +: 64] = 64'hA0 + 64'(k);
        xact(1'b0, 1'b1, 1'b0, 32'h1234_5678, '0, rl, -1, 0, 1'b0, 1'b0);
        model_rdata[0] = rl;
        n_tests++; if (o_timeout)                   begin n_fail++; $display("FAIL iread_timeout got no resp want resp"); end
        n_tests++; if (o_addr_first !== 32'h1234_5660) begin n_fail++; $display("FAIL iread_addr got %0h want 12345660", o_addr_first); end
        n_tests++; if (o_first_req_t != 1)          begin n_fail++; $display("FAIL iread_issue_cycle got %0d want 1", o_first_req_t); end
        n_tests++; if (o_rdata !== rl)              begin n_fail++; $display("FAIL iread_rdata got %0h want %0h", o_rdata, rl); end
        n_tests++; if (o_resp_t != 6 || o_last_beat_t != 5) begin n_fail++; $display("FAIL iread_resp_cycle got resp=%0d last=%0d want 6/5", o_resp_t, o_last_beat_t); end
        n_tests++; if (o_other_resp || o_resp_after) begin n_fail++; $display("FAIL iread_resp_pulse got other=%0b after=%0b want 0/0", o_other_resp, o_resp_after); end
        n_tests++; if (d_rdata !== model_rdata[1])  begin n_fail++; $display("FAIL iread_d_rdata got %0h want %0h", d_rdata, model_rdata[1]); end
    endtask

    task automatic test_dcache_write_stall();
        logic [LW-1:0] wl;
        wl = {64'h0000_0000_FFEE_DDCC, 64'h0000_0000_BBAA_9988,
              64'h0000_0000_7766_5544, 64'h0000_0000_3322_1100};
        xact(1'b1, 1'b0, 1'b1, 32'h0000_4A3C, wl, '0, 1, 2, 1'b0, 1'b0);
        n_tests++; if (o_beats.size() != BEATS) begin n_fail++; $display("FAIL dwrite_beat_count got %0d want %0d", o_beats.size(), BEATS); end
        for (int k = 0; k < BEATS && k < o_beats.size(); k++) begin
            n_tests++;
            if (o_beats[k] !== wl[k*64 +: 64]) begin n_fail++; $display("FAIL dwrite_beat%0d got %0h want %0h", k, o_beats[k], wl[k*64 +: 64]); end
        end
        n_tests++; if (o_hold_bad)             begin n_fail++; $display("FAIL dwrite_hold got changed want stable"); end
        n_tests++; if (o_resp_t != 7)          begin n_fail++; $display("FAIL dwrite_resp_cycle got %0d want 7", o_resp_t); end
        n_tests++; if (o_addr_first !== 32'h0000_4A20 || o_addr_bad) begin n_fail++; $display("FAIL dwrite_addr got %0h bad=%0b want 4a20", o_addr_first, o_addr_bad); end
        n_tests++; if (o_other_resp)           begin n_fail++; $display("FAIL dwrite_iresp got 1 want 0"); end
    endtask

    task automatic test_read_mismatch();
        logic [LW-1:0] rl;
        rl = rand_line();
        xact(1'b1, 1'b1, 1'b0, 32'h8000_0104, '0, rl, -1, 0, 1'b0, 1'b1);
        model_rdata[1] = rl;
        n_tests++; if (o_rdata !== rl) begin n_fail++; $display("FAIL mism_rdata got %0h want %0h", o_rdata, rl); end
        n_tests++; if (o_timeout || o_resp_t != o_last_beat_t + 1) begin n_fail++; $display("FAIL mism_resp_cycle got %0d want %0d", o_resp_t, o_last_beat_t + 1); end
        n_tests++; if (i_rdata !== model_rdata[0]) begin n_fail++; $display("FAIL mism_i_rdata_hold got %0h want %0h", i_rdata, model_rdata[0]); end
    endtask

    task automatic test_starvation();
        int ng, cnt, t;
        bit exp_i;
        ng = 0; cnt = 0; t = 0;
        @(negedge clk);
        i_addr = $urandom; i_write = 1'b1; i_wdata = rand_line();
        d_addr = $urandom; d_write = 1'b1; d_wdata = rand_line();
        while (ng < 10 && t < 2000) begin
            @(negedge clk);
            t++;
            bmem_ready = 1'b1;
            if (i_resp || d_resp) begin
                exp_i = (cnt == STARVE_MAX);
                cnt   = exp_i ? 0 : cnt + 1;
                n_tests++;
                if (i_resp !== exp_i || d_resp !== !exp_i) begin
                    n_fail++;
                    $display("FAIL starve_grant%0d got i=%0b d=%0b want i=%0b d=%0b", ng, i_resp, d_resp, exp_i, !exp_i);
                end
                ng++;
                if (ng == 10) begin
                    i_write = 1'b0; d_write = 1'b0;
                end else if (i_resp) begin
                    i_addr = $urandom; i_wdata = rand_line();
                end else begin
                    d_addr = $urandom; d_wdata = rand_line();
                end
            end
        end
        i_write = 1'b0; d_write = 1'b0;
        n_tests++; if (ng != 10) begin n_fail++; $display("FAIL starve_timeout got %0d grants want 10", ng); end
        @(negedge clk);
        bmem_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_midburst();
        logic [LW-1:0] rl;
        logic [31:0] ra;
        int acc;
        bit found;
        acc = 0; found = 0;
        @(negedge clk);
        d_addr = 32'h0000_9900; d_write = 1'b1; d_wdata = rand_line();
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            bmem_ready = 1'b1;
            if (bmem_write) begin
                if (acc == 2) found = 1;
                else acc++;
            end
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL rstmid_reach_beat2 got none want beat 2"); end
        rst = 1'b1; d_write = 1'b0; bmem_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bmem_read !== 1'b0 || bmem_write !== 1'b0 || bmem_addr !== '0 || bmem_wdata !== '0 ||
            i_resp !== 1'b0 || d_resp !== 1'b0 || i_rdata !== '0 || d_rdata !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs got rd=%0b wr=%0b addr=%0h wd=%0h ir=%0b dr=%0b want all 0",
                     bmem_read, bmem_write, bmem_addr, bmem_wdata, i_resp, d_resp);
        end
        rst = 1'b0;
        model_rdata[0] = '0;
        model_rdata[1] = '0;
        ra = 32'h00C0_FFE8;
        rl = rand_line();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bmem_rvalid = 1'b1; bmem_raddr = align(ra); bmem_rdata = {$urandom, $urandom};
        end
        xact(1'b0, 1'b1, 1'b0, ra, '0, rl, -1, 0, 1'b0, 1'b0);
        model_rdata[0] = rl;
        n_tests++; if (o_rdata !== rl) begin n_fail++; $display("FAIL rstmid_read_rdata got %0h want %0h", o_rdata, rl); end
        n_tests++; if (o_timeout || o_resp_t != 6) begin n_fail++; $display("FAIL rstmid_read_resp got %0d want 6", o_resp_t); end
        n_tests++; if (d_rdata !== '0) begin n_fail++; $display("FAIL rstmid_d_rdata got %0h want 0", d_rdata); end
    endtask

    task automatic test_random();
        logic [LW-1:0] wl, rl;
        logic [31:0] a;
        bit is_d, rd, wr, bad;
        int op;
        for (int n = 0; n < 24; n++) begin
            is_d = ($urandom_range(0, 1) == 1);
            op   = $urandom_range(0, 2);
            rd   = (op != 1);
            wr   = (op != 0);
            a    = $urandom;
            wl   = rand_line();
            rl   = rand_line();
            xact(is_d, rd, wr, a, wl, rl, -1, 0, 1'b1, ($urandom_range(0, 1) == 1));
            n_tests++;
            if (o_timeout || o_addr_bad || o_addr_first !== align(a) || o_other_resp || o_resp_after) begin
                n_fail++;
                $display("FAIL rand%0d_handshake got to=%0b addr=%0h other=%0b after=%0b want addr %0h",
                         n, o_timeout, o_addr_first, o_other_resp, o_resp_after, align(a));
            end
            if (wr) begin
                bad = (o_beats.size() != BEATS);
                for (int k = 0; k < BEATS && k < o_beats.size(); k++)
                    if (o_beats[k] !== wl[k*64 +: 64]) bad = 1;
                n_tests++;
                if (bad || o_hold_bad) begin n_fail++; $display("FAIL rand%0d_wbeats got %0d beats hold_bad=%0b want line %0h", n, o_beats.size(), o_hold_bad, wl); end
                n_tests++;
                if (o_resp_t != 1 + BEATS + o_nstall) begin n_fail++; $display("FAIL rand%0d_wresp got %0d want %0d", n, o_resp_t, 1 + BEATS + o_nstall); end
            end else begin
                model_rdata[is_d] = rl;
                n_tests++;
                if (o_rdata !== rl) begin n_fail++; $display("FAIL rand%0d_rdata got %0h want %0h", n, o_rdata, rl); end
                n_tests++;
                if (o_resp_t != o_last_beat_t + 1) begin n_fail++; $display("FAIL rand%0d_rresp got %0d want %0d", n, o_resp_t, o_last_beat_t + 1); end
            end
            n_tests++;
            if (i_rdata !== model_rdata[0] || d_rdata !== model_rdata[1]) begin
                n_fail++;
                $display("FAIL rand%0d_rdata_hold got i=%0h d=%0h want i=%0h d=%0h", n, i_rdata, d_rdata, model_rdata[0], model_rdata[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_icache_read();
        test_dcache_write_stall();
        test_read_mismatch();
        test_starvation();
        test_reset_midburst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule
